// File: rtl/mul_grs_pipe.sv
// Two-stage normalise / guard-round-sticky extraction for the multiplier datapath.
// Stage 1 selects the normalisation window and forms chunked partial ORs; stage 2 folds them into Sticky.
module mul_grs_pipe #(
    parameter int MANT_W  = 24,
    parameter int CHUNK_W = 4,
    parameter int TAG_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [2*MANT_W-1:0]   Product,
    input  logic                  InSticky,
    input  logic [TAG_W-1:0]      InTag,
    input  logic                  Flush,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [MANT_W-1:0]     Mant,
    output logic                  Guard,
    output logic                  Round,
    output logic                  Sticky,
    output logic                  NormShift,
    output logic [TAG_W-1:0]      OutTag
);

    localparam int PROD_W = 2 * MANT_W;
    localparam int DISC_W = MANT_W - 2;
    localparam int NCHUNK = (DISC_W + CHUNK_W - 1) / CHUNK_W;
    localparam int PAD_W  = NCHUNK * CHUNK_W;

    logic                 w_top;
    logic [MANT_W-1:0]    w_mant;
    logic                 w_guard;
    logic                 w_round;
    logic [DISC_W-1:0]    w_disc;
    logic [PAD_W-1:0]     w_disc_ext;
    logic [NCHUNK-1:0]    w_part;
    logic                 w_s1_load;
    logic                 w_s2_load;

    logic                 r_s1_vld;
    logic [MANT_W-1:0]    r_s1_mant;
    logic                 r_s1_guard;
    logic                 r_s1_round;
    logic                 r_s1_norm;
    logic                 r_s1_insticky;
    logic [NCHUNK-1:0]    r_s1_part;
    logic [TAG_W-1:0]     r_s1_tag;

    logic                 r_s2_vld;
    logic [MANT_W-1:0]    r_s2_mant;
    logic                 r_s2_guard;
    logic                 r_s2_round;
    logic                 r_s2_sticky;
    logic                 r_s2_norm;
    logic [TAG_W-1:0]     r_s2_tag;

    assign w_top = Product[PROD_W-1];

    // With the MSB clear the window slides down one bit, so the bottom
    // discarded position is padded with a zero to keep DISC_W bits.
    always_comb begin
        if (w_top) begin
            w_mant  = Product[PROD_W-1:MANT_W];
            w_guard = Product[MANT_W-1];
            w_round = Product[MANT_W-2];
            w_disc  = Product[MANT_W-3:0];
        end else begin
            w_mant  = Product[PROD_W-2:MANT_W-1];
            w_guard = Product[MANT_W-2];
            w_round = Product[MANT_W-3];
            w_disc  = {Product[MANT_W-4:0], 1'b0};
        end
    end

    always_comb begin
        w_disc_ext = '0;
        w_disc_ext[DISC_W-1:0] = w_disc;
        w_part = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            w_part[c] = |w_disc_ext[c*CHUNK_W +: CHUNK_W];
        end
    end

    assign w_s2_load = !r_s2_vld || OutReady;
    assign w_s1_load = !r_s1_vld || w_s2_load;
    assign InReady   = w_s1_load;

    // Stage 1: normalised fields and partial ORs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld      <= 1'b0;
            r_s1_mant     <= '0;
            r_s1_guard    <= 1'b0;
            r_s1_round    <= 1'b0;
            r_s1_norm     <= 1'b0;
            r_s1_insticky <= 1'b0;
            r_s1_part     <= '0;
            r_s1_tag      <= '0;
        end else begin
            if (Flush) begin
                r_s1_vld <= 1'b0;
            end else if (w_s1_load) begin
                r_s1_vld <= InValid;
            end
            if (w_s1_load && InValid && !Flush) begin
                r_s1_mant     <= w_mant;
                r_s1_guard    <= w_guard;
                r_s1_round    <= w_round;
                r_s1_norm     <= w_top;
                r_s1_insticky <= InSticky;
                r_s1_part     <= w_part;
                r_s1_tag      <= InTag;
            end
        end
    end

    // Stage 2: sticky reduction, drives the outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_vld    <= 1'b0;
            r_s2_mant   <= '0;
            r_s2_guard  <= 1'b0;
            r_s2_round  <= 1'b0;
            r_s2_sticky <= 1'b0;
            r_s2_norm   <= 1'b0;
            r_s2_tag    <= '0;
        end else begin
            if (Flush) begin
                r_s2_vld <= 1'b0;
            end else if (w_s2_load) begin
                r_s2_vld <= r_s1_vld;
            end
            if (w_s2_load && r_s1_vld && !Flush) begin
                r_s2_mant   <= r_s1_mant;
                r_s2_guard  <= r_s1_guard;
                r_s2_round  <= r_s1_round;
                r_s2_sticky <= (|r_s1_part) | r_s1_insticky;
                r_s2_norm   <= r_s1_norm;
                r_s2_tag    <= r_s1_tag;
            end
        end
    end

    assign OutValid  = r_s2_vld;
    assign Mant      = r_s2_mant;
    assign Guard     = r_s2_guard;
    assign Round     = r_s2_round;
    assign Sticky    = r_s2_sticky;
    assign NormShift = r_s2_norm;
    assign OutTag    = r_s2_tag;

endmodule

// File: tb/tb_mul_grs_pipe.sv
// Bench for mul_grs_pipe: directed cases plus randomized traffic against an arithmetic reference model.
module tb_mul_grs_pipe;

    localparam int MANT_W = 24;
    localparam int TAG_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              InValid;
    logic              InReady;
    logic [47:0]       Product;
    logic              InSticky;
    logic [TAG_W-1:0]  InTag;
    logic              Flush;
    logic              OutValid;
    logic              OutReady;
    logic [23:0]       Mant;
    logic              Guard;
    logic              Round;
    logic              Sticky;
    logic              NormShift;
    logic [TAG_W-1:0]  OutTag;
    logic [31:0]       w_got;

    int total = 0;
    int bad   = 0;

    logic [31:0] q_exp[$];
    logic        hold_vld = 1'b0;
    logic [31:0] hold_val = '0;

    mul_grs_pipe #(.MANT_W(MANT_W), .CHUNK_W(5), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .InValid(InValid), .InReady(InReady),
        .Product(Product), .InSticky(InSticky), .InTag(InTag), .Flush(Flush),
        .OutValid(OutValid), .OutReady(OutReady), .Mant(Mant), .Guard(Guard),
        .Round(Round), .Sticky(Sticky), .NormShift(NormShift), .OutTag(OutTag)
    );

    always #5 clk = ~clk;

    assign w_got = {OutTag, Mant, Guard, Round, Sticky, NormShift};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: the product value is treated as an integer; the kept
    // mantissa is its top 24 significant bits, everything below is rounding info.
    function automatic logic [31:0] ref_out(input logic [47:0] p, input logic ins, input logic [3:0] tag);
        longint unsigned v;
        int sh;
        logic [23:0] m;
        logic g, r, s, ns;
        v  = 64'(p);
        ns = (v >= (64'd1 << 47));
        sh = ns ? 24 : 23;
        m  = 24'((v >> sh) % (64'd1 << 24));
        g  = ((v >> (sh - 1)) % 2) == 1;
        r  = ((v >> (sh - 2)) % 2) == 1;
        s  = (v % (64'd1 << (sh - 2))) != 0 || ins;
        return {tag, m, g, r, s, ns};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q_exp.delete();
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) chk("hold_stable", {OutValid, w_got}, {1'b1, hold_val});
            if (Flush) begin
                q_exp.delete();
            end else begin
                if (OutValid && OutReady) begin
                    if (q_exp.size() == 0) chk("unexpected_out", 64'(OutValid), 64'd0);
                    else chk("sb_data", 64'(w_got), 64'(q_exp.pop_front()));
                end
                if (InValid && InReady) q_exp.push_back(ref_out(Product, InSticky, InTag));
            end
            hold_vld = OutValid && !OutReady && !Flush;
            hold_val = w_got;
        end
    end

    task automatic drive(input logic [47:0] p, input logic ins, input logic [3:0] tag);
        InValid  = 1'b1;
        Product  = p;
        InSticky = ins;
        InTag    = tag;
    endtask

    task automatic send1(input logic [47:0] p, input logic ins, input logic [3:0] tag);
        drive(p, ins, tag);
        @(posedge clk); #1;
        InValid = 1'b0;
    endtask

    task automatic expect2(input string name, input logic [47:0] p, input logic ins, input logic [3:0] tag);
        @(negedge clk);
        chk({name, "_lat1"}, 64'(OutValid), 64'd0);
        @(negedge clk);
        chk({name, "_lat2"}, 64'(OutValid), 64'd1);
        chk({name, "_data"}, 64'(w_got), 64'(ref_out(p, ins, tag)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; InValid = 0; Product = '0; InSticky = 0; InTag = '0;
        Flush = 0; OutReady = 1'b1;
        #1;
        chk("rst_outs", {31'd0, OutValid, w_got}, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_inready", 64'(InReady), 64'd1);

        // Directed normalisation cases with known results
        send1(48'h8000_0000_0001, 1'b0, 4'd1);
        expect2("t1", 48'h8000_0000_0001, 1'b0, 4'd1);
        chk("t1_const", 64'(w_got), {32'd0, 4'd1, 24'h800000, 4'b0011});
        send1(48'h4000_0080_0000, 1'b0, 4'd2);
        expect2("t2", 48'h4000_0080_0000, 1'b0, 4'd2);
        chk("t2_const", 64'(w_got), {32'd0, 4'd2, 24'h800001, 4'b0000});
        send1(48'hC000_00C0_0000, 1'b1, 4'd3);
        expect2("t3", 48'hC000_00C0_0000, 1'b1, 4'd3);
        chk("t3_const", 64'(w_got), {32'd0, 4'd3, 24'hC00000, 4'b1111});
        send1(48'h8000_0000_0001, 1'b0, 4'd4);
        expect2("t5a", 48'h8000_0000_0001, 1'b0, 4'd4);
        send1(48'h8000_0020_0000, 1'b0, 4'd5);
        expect2("t5_lastchunk", 48'h8000_0020_0000, 1'b0, 4'd5);
        chk("t5_lastchunk_s", 64'(Sticky), 64'd1);
        send1(48'h4000_0010_0000, 1'b0, 4'd6);
        expect2("t5_shift0", 48'h4000_0010_0000, 1'b0, 4'd6);
        chk("t5_shift0_s", 64'(Sticky), 64'd1);
        send1(48'h0, 1'b1, 4'd7);
        expect2("zero", 48'h0, 1'b1, 4'd7);
        chk("zero_const", 64'(w_got), {32'd0, 4'd7, 24'h0, 4'b0010});

        // Backpressure: two accepted, third stalls, drain in order
        @(posedge clk); #1;
        OutReady = 1'b0;
        drive(48'h1234_5678_9ABC, 1'b0, 4'd1);
        @(negedge clk); chk("bp_rdy1", 64'(InReady), 64'd1);
        @(posedge clk); #1; drive(48'h8765_4321_0FED, 1'b0, 4'd2);
        @(negedge clk); chk("bp_rdy2", 64'(InReady), 64'd1);
        @(posedge clk); #1; drive(48'hFFFF_FFFF_FFFF, 1'b0, 4'd3);
        @(negedge clk); chk("bp_rdy3", 64'(InReady), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); chk("bp_hold_tag", 64'(OutTag), 64'd1);
        @(posedge clk); #1; OutReady = 1'b1;
        @(negedge clk); chk("bp_out1", 64'({OutValid, OutTag}), {59'd0, 1'b1, 4'd1});
        @(posedge clk); #1; InValid = 1'b0;
        @(negedge clk); chk("bp_out2", 64'({OutValid, OutTag}), {59'd0, 1'b1, 4'd2});
        @(negedge clk); chk("bp_out3", 64'({OutValid, OutTag}), {59'd0, 1'b1, 4'd3});
        @(negedge clk); chk("bp_empty", 64'(OutValid), 64'd0);

        // Flush with two results in flight and an input in the same cycle
        @(posedge clk); #1;
        drive(48'h0000_1111_2222, 1'b0, 4'd8);
        @(posedge clk); #1; drive(48'h0000_3333_4444, 1'b0, 4'd9);
        @(posedge clk); #1; drive(48'h0000_5555_6666, 1'b0, 4'd10); Flush = 1'b1;
        @(posedge clk); #1; InValid = 1'b0; Flush = 1'b0;
        @(negedge clk); chk("flush_vld", 64'(OutValid), 64'd0);
        @(negedge clk); chk("flush_vld2", 64'(OutValid), 64'd0);
        @(posedge clk); #1;
        send1(48'hA5A5_5A5A_0001, 1'b0, 4'd11);
        expect2("post_flush", 48'hA5A5_5A5A_0001, 1'b0, 4'd11);

        // Asynchronous reset mid-flight
        @(posedge clk); #1;
        drive(48'hF0F0_0F0F_1234, 1'b1, 4'd12);
        @(posedge clk); #1; drive(48'h7777_0000_0003, 1'b0, 4'd13);
        @(posedge clk); #1; InValid = 1'b0; rst = 1'b1;
        #1 chk("mid_rst", {31'd0, OutValid, w_got}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        chk("mid_rst_rdy", 64'(InReady), 64'd1);
        send1(48'h6000_0000_0000, 1'b0, 4'd14);
        expect2("post_rst", 48'h6000_0000_0000, 1'b0, 4'd14);

        // Randomized traffic with backpressure and occasional flush
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            InValid  = ($urandom_range(0, 9) < 7);
            OutReady = ($urandom_range(0, 9) < 6);
            Flush    = ($urandom_range(0, 99) < 2);
            InSticky = ($urandom_range(0, 3) == 0);
            InTag    = 4'(i);
            case ($urandom_range(0, 3))
                0: begin
                    Product[47:32] = 16'($urandom());
                    Product[31:0]  = $urandom();
                end
                1: Product = 48'd1 << $urandom_range(0, 47);
                2: Product = (48'd1 << 47) | (48'd1 << $urandom_range(0, 23));
                default: Product = (48'd1 << 46) | (48'd1 << $urandom_range(0, 23));
            endcase
        end
        @(posedge clk); #1;
        InValid = 1'b0; Flush = 1'b0; OutReady = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("drain", 64'(q_exp.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
